// File: rtl/store_pkg.sv
// Shared types for the store buffer / drain engine.
package store_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'd0,
        SIZE_H   = 2'd1,
        SIZE_W   = 2'd2,
        SIZE_ILL = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ILL  = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] val;
        mem_size_t   size;
    } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Maps a store (byte address, right-justified value, size) onto the 32-bit bus lanes.
module store_lane_align
    import store_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [31:0] val,
    input  mem_size_t   size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb
);

    assign mem_addr = {addr[31:2], 2'b00};

    // Narrow stores are replicated across lanes so the strobe alone selects the bytes.
    always_comb begin
        mem_wdata = '0;
        mem_wstrb = '0;
        case (size)
            SIZE_B: begin
                mem_wdata = {4{val[7:0]}};
                mem_wstrb = 4'b0001 << addr[1:0];
            end
            SIZE_H: begin
                mem_wdata = {2{val[15:0]}};
                mem_wstrb = 4'b0011 << addr[1:0];
            end
            SIZE_W: begin
                mem_wdata = val;
                mem_wstrb = 4'b1111;
            end
            default: begin
                mem_wdata = '0;
                mem_wstrb = '0;
            end
        endcase
    end

endmodule

// File: rtl/store_drain.sv
// In-order store buffer that drains committed stores to the data memory bus
// over a req/ack handshake, with load-hazard detection and error reporting.
module store_drain
    import store_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] datafifo_addr_in,
    input  logic [31:0] datafifo_val_in,
    input  logic [1:0]  datafifo_size_in,
    input  logic        datafifo_valid_in,
    output logic        datafifo_full,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] load_addr,
    output logic        load_hazard,
    output logic        store_err_valid,
    output logic [31:0] store_err_addr,
    output logic        drain_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    store_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    drain_state_t     state;

    store_entry_t     head_e;
    store_entry_t     push_e;
    mem_size_t        next_head_size;
    logic             push;
    logic             pop;
    logic             ack_pop;
    logic             ill_pop;
    logic [31:0]      al_addr;
    logic [31:0]      al_wdata;
    logic [3:0]       al_wstrb;
    logic             unused_load_bits;

    assign unused_load_bits = ^load_addr[1:0];

    assign push_e = '{addr: datafifo_addr_in,
                      val:  datafifo_val_in,
                      size: mem_size_t'(datafifo_size_in)};
    assign head_e = entries[head];

    assign datafifo_full = (count == CNT_W'(DEPTH));
    assign push          = datafifo_valid_in && !datafifo_full && !reset;
    assign mem_req       = (state == REQ);
    assign ack_pop       = mem_req && mem_ack;
    assign ill_pop       = (state == ILL);
    assign pop           = ack_pop || ill_pop;
    assign count_next    = count + CNT_W'(push) - CNT_W'(pop);
    assign drain_empty   = (count == '0) && (state == IDLE);

    // With one entry left, the only way to stay non-empty after a pop is a same-cycle push.
    assign next_head_size = (count == CNT_W'(1)) ? push_e.size
                                                 : entries[head + PTR_W'(1)].size;

    store_lane_align u_align (
        .addr      (head_e.addr),
        .val       (head_e.val),
        .size      (head_e.size),
        .mem_addr  (al_addr),
        .mem_wdata (al_wdata),
        .mem_wstrb (al_wstrb)
    );

    assign mem_addr  = mem_req ? al_addr  : '0;
    assign mem_wdata = mem_req ? al_wdata : '0;
    assign mem_wstrb = mem_req ? al_wstrb : '0;

    // Hazard covers every queued entry plus the store being accepted this cycle.
    always_comb begin
        logic [PTR_W-1:0] idx;
        load_hazard = push && (push_e.addr[31:2] == load_addr[31:2]);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr[31:2] == load_addr[31:2])) begin
                load_hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= push_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            store_err_valid <= 1'b0;
            store_err_addr  <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count           <= count_next;
            store_err_valid <= 1'b0;
            if ((ack_pop && mem_err) || ill_pop) begin
                store_err_valid <= 1'b1;
                store_err_addr  <= head_e.addr;
            end
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= (head_e.size == SIZE_ILL) ? ILL : REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (count_next == '0) begin
                            state <= IDLE;
                        end else begin
                            state <= (next_head_size == SIZE_ILL) ? ILL : REQ;
                        end
                    end
                end
                ILL:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_drain.sv
// Directed stimulus with a queue-based scoreboard for store_drain.
module tb_store_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] datafifo_addr_in;
    logic [31:0] datafifo_val_in;
    logic [1:0]  datafifo_size_in;
    logic        datafifo_valid_in;
    logic        datafifo_full;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] load_addr;
    logic        load_hazard;
    logic        store_err_valid;
    logic [31:0] store_err_addr;
    logic        drain_empty;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } bus_exp_t;

    bus_exp_t    exp_q[$];
    logic [31:0] err_q[$];
    int          checks = 0;
    int          errors = 0;

    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_wstrb;

    store_drain #(.DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .datafifo_addr_in  (datafifo_addr_in),
        .datafifo_val_in   (datafifo_val_in),
        .datafifo_size_in  (datafifo_size_in),
        .datafifo_valid_in (datafifo_valid_in),
        .datafifo_full     (datafifo_full),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_wstrb         (mem_wstrb),
        .mem_req           (mem_req),
        .mem_ack           (mem_ack),
        .mem_err           (mem_err),
        .load_addr         (load_addr),
        .load_hazard       (load_hazard),
        .store_err_valid   (store_err_valid),
        .store_err_addr    (store_err_addr),
        .drain_empty       (drain_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] sz,
                        input bit track, input logic [31:0] ea, input logic [31:0] ed,
                        input logic [3:0] es);
        datafifo_addr_in  = a;
        datafifo_val_in   = v;
        datafifo_size_in  = sz;
        datafifo_valid_in = 1'b1;
        if (track) exp_q.push_back('{a: ea, d: ed, s: es});
        tick();
        datafifo_valid_in = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check(nm, 32'(mem_req), 32'd1);
    endtask

    task automatic ack_one(input logic err);
        mem_ack = 1'b1;
        mem_err = err;
        tick();
        mem_ack = 1'b0;
        mem_err = 1'b0;
    endtask

    task automatic expect_no_req(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mem_req) seen++;
        end
        check(nm, 32'(seen), 32'd0);
    endtask

    // Scoreboard monitor: compares every accepted bus write and every error pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req) begin
                if (prev_wait) begin
                    check("bus_stable_addr", mem_addr, prev_addr);
                    check("bus_stable_data", mem_wdata, prev_wdata);
                    check("bus_stable_strb", 32'(mem_wstrb), 32'(prev_wstrb));
                end
                if (mem_ack) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_req: got addr %h, required no request", mem_addr);
                    end else begin
                        bus_exp_t e;
                        e = exp_q.pop_front();
                        if (mem_addr !== e.a || mem_wdata !== e.d || mem_wstrb !== e.s) begin
                            errors++;
                            $display("FAIL bus_write: got %h/%h/%b expected %h/%h/%b",
                                     mem_addr, mem_wdata, mem_wstrb, e.a, e.d, e.s);
                        end
                    end
                end
            end else if (prev_wait) begin
                check("req_dropped_without_ack", 32'(mem_req), 32'd1);
            end else begin
                check("idle_bus_zero", 32'(|{mem_addr, mem_wdata, mem_wstrb}), 32'd0);
            end
            if (store_err_valid) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err: got addr %h, required no pulse", store_err_addr);
                end else begin
                    logic [31:0] ea;
                    ea = err_q.pop_front();
                    if (store_err_addr !== ea) begin
                        errors++;
                        $display("FAIL err_addr: got %h expected %h", store_err_addr, ea);
                    end
                end
            end
        end
        prev_wait  = mem_req && !mem_ack && !reset;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_wstrb = mem_wstrb;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        datafifo_addr_in  = '0;
        datafifo_val_in   = '0;
        datafifo_size_in  = '0;
        datafifo_valid_in = 1'b0;
        mem_ack           = 1'b0;
        mem_err           = 1'b0;
        load_addr         = '0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_full", 32'(datafifo_full), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_err_valid", 32'(store_err_valid), 32'd0);
        check("rst_err_addr", store_err_addr, 32'd0);
        check("rst_hazard", 32'(load_hazard), 32'd0);
        check("rst_drain_empty", 32'(drain_empty), 32'd1);
        tick();

        // Single word store and push-to-request latency
        push(32'h1000_0006, 32'hDEAD_BEEF, 2'd2, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b1111);
        @(negedge clk);
        check("lat_early_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("lat_req", 32'(mem_req), 32'd1);
        check("busy_drain_empty", 32'(drain_empty), 32'd0);
        tick();
        ack_one(1'b0);
        @(negedge clk);
        check("word_drain_empty", 32'(drain_empty), 32'd1);
        tick();

        // Byte and half lanes, back-to-back acks
        push(32'h0000_0203, 32'h0000_00AB, 2'd0, 1'b1, 32'h0000_0200, 32'hABAB_ABAB, 4'b1000);
        push(32'h0000_0202, 32'h0000_1234, 2'd1, 1'b1, 32'h0000_0200, 32'h1234_1234, 4'b1100);
        wait_req("lane_req0");
        ack_one(1'b0);
        wait_req("lane_req1");
        ack_one(1'b0);
        check("lane_done_req", 32'(mem_req), 32'd0);

        // Fill and back-pressure
        push(32'h0000_0100, 32'h1, 2'd2, 1'b1, 32'h0000_0100, 32'h1, 4'b1111);
        push(32'h0000_0104, 32'h2, 2'd2, 1'b1, 32'h0000_0104, 32'h2, 4'b1111);
        push(32'h0000_0108, 32'h3, 2'd2, 1'b1, 32'h0000_0108, 32'h3, 4'b1111);
        check("not_full_at3", 32'(datafifo_full), 32'd0);
        push(32'h0000_010C, 32'h4, 2'd2, 1'b1, 32'h0000_010C, 32'h4, 4'b1111);
        check("full_at4", 32'(datafifo_full), 32'd1);
        push(32'h0000_0110, 32'h5, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0);
        check("full_after_drop", 32'(datafifo_full), 32'd1);
        check("fill_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        check("full_clear", 32'(datafifo_full), 32'd0);
        repeat (3) tick();
        mem_ack = 1'b0;
        check("fill_done_req", 32'(mem_req), 32'd0);
        check("fill_drain_empty", 32'(drain_empty), 32'd1);
        expect_no_req("dropped_never_issued", 4);
        tick();

        // Load hazard
        load_addr         = 32'h3000_0003;
        datafifo_addr_in  = 32'h3000_0001;
        datafifo_val_in   = 32'h0000_005A;
        datafifo_size_in  = 2'd0;
        datafifo_valid_in = 1'b1;
        exp_q.push_back('{a: 32'h3000_0000, d: 32'h5A5A_5A5A, s: 4'b0010});
        #1;
        check("hazard_push_cycle", 32'(load_hazard), 32'd1);
        tick();
        datafifo_valid_in = 1'b0;
        #1;
        check("hazard_pending", 32'(load_hazard), 32'd1);
        load_addr = 32'h3000_0004;
        #1;
        check("hazard_other_word", 32'(load_hazard), 32'd0);
        load_addr = 32'h3000_0003;
        wait_req("hazard_req");
        ack_one(1'b0);
        #1;
        check("hazard_after_ack", 32'(load_hazard), 32'd0);

        // Bus error keeps draining; illegal size pulses without a request
        err_q.push_back(32'h0000_0040);
        push(32'h0000_0040, 32'h1111_1111, 2'd2, 1'b1, 32'h0000_0040, 32'h1111_1111, 4'b1111);
        push(32'h0000_0044, 32'h2222_2222, 2'd2, 1'b1, 32'h0000_0044, 32'h2222_2222, 4'b1111);
        wait_req("err_req0");
        ack_one(1'b1);
        wait_req("err_req1");
        ack_one(1'b0);
        tick();
        err_q.push_back(32'h0000_0055);
        push(32'h0000_0055, 32'h0, 2'd3, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_no_req("ill_no_req", 6);
        check("ill_err_seen", 32'(err_q.size()), 32'd0);
        check("ill_drain_empty", 32'(drain_empty), 32'd1);
        tick();

        // Reset mid-request with three entries queued
        push(32'h0000_0500, 32'h5, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0);
        push(32'h0000_0504, 32'h6, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0);
        push(32'h0000_0508, 32'h7, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("pre_reset_req", 32'(mem_req), 32'd1);
        tick();
        reset   = 1'b1;
        mem_ack = 1'b1;
        tick();
        reset   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        check("post_reset_req", 32'(mem_req), 32'd0);
        check("post_reset_drain_empty", 32'(drain_empty), 32'd1);
        check("post_reset_full", 32'(datafifo_full), 32'd0);
        expect_no_req("post_reset_quiet", 8);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_drain.md
# store_drain

Store buffer and drain engine on the consumer side of the commit stage's data FIFO interface. It accepts committed stores (address, value, size) into an in-order queue and asserts `datafifo_full` as back-pressure. It retires each store to the data memory bus through a req/ack handshake, generating word-aligned address, lane-replicated write data and byte strobes. It also flags load hazards against pending stores and reports bus write errors.

## Interface
- `DEPTH`, default 4: queue entries; power of two, ≥2.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `datafifo_addr_in` input, 32 bits: store byte address.
- `datafifo_val_in` input, 32 bits: store value, right-justified.
- `datafifo_size_in` input, 2 bits: 0 byte, 1 half, 2 word, 3 illegal.
- `datafifo_valid_in` input, 1 bit: push request.
- `datafifo_full` output, 1 bit: queue holds `DEPTH` entries.
- `mem_addr` output, 32 bits: word-aligned write address.
- `mem_wdata` output, 32 bits: lane-replicated write data.
- `mem_wstrb` output, 4 bits: byte enables.
- `mem_req` output, 1 bit: write request.
- `mem_ack` input, 1 bit: write accepted/completed.
- `mem_err` input, 1 bit: bus error; sampled only with `mem_ack`.
- `load_addr` input, 32 bits: address of the load currently in execute.
- `load_hazard` output, 1 bit: a pending store overlaps the word at `load_addr`.
- `store_err_valid` output, 1 bit: one-cycle error pulse.
- `store_err_addr` output, 32 bits: byte address of the faulting store.
- `drain_empty` output, 1 bit: queue empty and no request in flight; used for fence.

## Operation
- **Queue**
  - Circular buffer with head/tail pointers of `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
  - Separate count register of `$clog2(DEPTH)+1` bits.
  - `datafifo_full` = (count == `DEPTH`), combinational from count.
- **Push**
  - Occurs when `datafifo_valid_in && !datafifo_full`.
  - A push attempted while full is dropped; the commit stage never does this.
  - A push while full is not accepted even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves count unchanged.
- **FSM states**
  - IDLE: if count > 0, go to REQ.
  - REQ: `mem_req` = 1, and bus outputs are driven from the head entry. On `mem_ack`: pop the head. If count after the pop is > 0, stay in REQ (back-to-back); otherwise go to IDLE.
  - ILL: entered from IDLE or after an ack when the head has size 3. Pops the head with no bus request, pulses the error, then returns to IDLE.
- **Bus output stability**: `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable while `mem_req` is high and `mem_ack` is low. When `mem_req` = 0, these outputs are 0.
- **Lane alignment**
  - `mem_addr` = {addr[31:2], 2'b00}.
  - Size 0: `mem_wdata` = {4{val[7:0]}}, `mem_wstrb` = 4'b0001 << addr[1:0].
  - Size 1: `mem_wdata` = {2{val[15:0]}}, `mem_wstrb` = 4'b0011 << addr[1:0]. addr[0] is guaranteed 0 upstream.
  - Size 2: `mem_wdata` = val, `mem_wstrb` = 4'b1111.
- **Errors**
  - Cycle after an ack with `mem_err` = 1: `store_err_valid` = 1 and `store_err_addr` = the popped store's byte address. Draining continues.
  - Size 3 (ILL state) produces the same pulse.
- **Load hazard**: `load_hazard` is combinational. It is 1 if any valid entry, including the in-flight head or an accepted push in the current cycle, has addr[31:2] == `load_addr`[31:2].

## Timing
- **Push to request latency**
  - Push accepted at edge N; the entry is counted after N.
  - FSM leaves IDLE at N+1.
  - `mem_req` is high during the cycle after N+1.
  - Minimum is 2 cycles from `datafifo_valid_in` to `mem_req`.
- **Throughput**: back-to-back acks give 1 store per cycle.
- **Pop and full**: the pop takes effect at the ack edge, and `datafifo_full` drops the same cycle after that edge.
- **Reset values**: `datafifo_full` 0, `mem_req` 0, `mem_addr` 0, `mem_wdata` 0, `mem_wstrb` 0, `store_err_valid` 0, `store_err_addr` 0, `load_hazard` 0, `drain_empty` 1. Pointers and count are 0 and the FSM is in IDLE.
- **Reset mid-transaction**: reset discards all entries and abandons the in-flight request. `mem_req` is 0 in the cycle after the reset edge. An ack arriving during reset is ignored.

## Structure
- Shared package `store_pkg`:
  - `mem_size_t` enum: SIZE_B = 0, SIZE_H = 1, SIZE_W = 2, SIZE_ILL = 3.
  - `drain_state_t` enum: IDLE, REQ, ILL.
  - `store_entry_t` struct: addr, val, size.
- One combinational sub-module, `store_lane_align` (addr, val, size → `mem_addr`, `mem_wdata`, `mem_wstrb`), instantiated on the head entry.

## Test plan
- **Single word store**: push addr 0x1000_0006, size 2, val 0xDEADBEEF; ack one cycle after `mem_req`. Expect `mem_req` 2 cycles after the push, then `mem_addr` 0x1000_0004, `mem_wdata` 0xDEADBEEF, `mem_wstrb` 4'b1111, and `drain_empty` = 1 afterwards.
- **Byte and half lanes**: push a byte at 0x203 with val 0xAB, then a half at 0x202 with val 0x1234. Expect `mem_wdata` 0xABABABAB with `mem_wstrb` 4'b1000, then `mem_wdata` 0x12341234 with `mem_wstrb` 4'b1100.
- **Fill and back-pressure**: with `mem_ack` held at 0, push 5 stores (DEPTH = 4). Expect `datafifo_full` = 1 after the 4th push, and the 5th store is never issued. Then ack every cycle: expect 4 requests in issue order, and full clears after the first ack.
- **Load hazard**: pending store at 0x3000_0001 with `load_addr` 0x3000_0003 gives `load_hazard` = 1; `load_addr` 0x3000_0004 gives 0; after the ack, 0x3000_0003 gives 0.
- **Errors**: ack with `mem_err` = 1 on a store to 0x40. Expect `store_err_valid` for exactly 1 cycle with `store_err_addr` 0x40, and the next store still issues. A size-3 push produces the error pulse with no `mem_req`.
- **Reset mid-request**: assert `reset` while `mem_req` = 1 with 3 entries queued. Expect `mem_req` 0 the next cycle, `drain_empty` 1, and no further requests after reset releases.
